// File: rtl/puf_challenge_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
//   Shared definitions for the RO-PUF challenge sequencer:
//     - state_t        : sequencer FSM states
//     - DEFAULT_CNT_W  : default oscillator counter width
//     - DEFAULT_SEL_W  : default oscillator select (challenge) width
//     - clog2()        : ceiling log2, never less than 1, usable in port widths
// -----------------------------------------------------------------------------
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_SETTLE,
        ST_SAMPLE,
        ST_OUTPUT
    } state_t;

    localparam int DEFAULT_CNT_W = 8;
    localparam int DEFAULT_SEL_W = 5;

    // Bits needed to hold the values 0..n-1; a minimum of 1 keeps vectors legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/puf_challenge_sequencer_window_timer.sv
// -----------------------------------------------------------------------------
// puf_window_timer
//   Loadable down-counter used for both the oscillation window and the
//   settle interval. Loading value N-1 makes 'expire' go high in the N-th
//   cycle after the load, so the owning state lasts exactly N cycles.
// Ports
//   clk         in   1      system clock
//   rst_n       in   1      asynchronous reset, active-high
//   load        in   1      load load_value on the next clock edge
//   load_value  in   WIDTH  value to load (interval length minus one)
//   expire      out  1      high while the count has reached zero
// -----------------------------------------------------------------------------
module puf_window_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    // NOTE: this codebase's rst_n asserts on a high level, so the reset
    // branch triggers on posedge rst_n and tests rst_n, not !rst_n.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/puf_challenge_sequencer.sv
// -----------------------------------------------------------------------------
// puf_challenge_sequencer
//   Challenge-side controller for an RO-PUF. For each of NBITS challenges it
//   clears both counter banks, enables the oscillators for WIN_CYCLES cycles,
//   waits SETTLE cycles for the counts to freeze, then records
//   (count_a > count_b) as response bit k. The finished word is offered on a
//   valid/ready handshake. Per challenge: 1 CLEAR + WIN_CYCLES RUN +
//   SETTLE + 1 SAMPLE cycles.
// Ports
//   clk, rst_n            clock, asynchronous active-high reset
//   start, sel_start      run request (ignored while busy) and first challenge
//   count_a, count_b      frozen counter values from banks A and B
//   osc_sel               oscillator select to both banks
//   osc_en, cnt_clr       oscillator enable / counter clear (never together)
//   busy                  high from accepted start until response accepted
//   resp_data, resp_ties  response word (bit k = challenge k) and tie count
//   resp_valid,resp_ready response handshake
// -----------------------------------------------------------------------------
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int SEL_W      = DEFAULT_SEL_W,
    parameter int NBITS      = 16,
    parameter int WIN_CYCLES = 256,
    parameter int SETTLE     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [SEL_W-1:0]           sel_start,
    input  logic [CNT_W-1:0]           count_a,
    input  logic [CNT_W-1:0]           count_b,
    output logic [SEL_W-1:0]           osc_sel,
    output logic                       osc_en,
    output logic                       cnt_clr,
    output logic                       busy,
    output logic [NBITS-1:0]           resp_data,
    output logic [clog2(NBITS+1)-1:0]  resp_ties,
    output logic                       resp_valid,
    input  logic                       resp_ready
);

    localparam int TIE_W   = clog2(NBITS + 1);
    localparam int IDX_W   = clog2(NBITS);
    localparam int TMR_MAX = (WIN_CYCLES > SETTLE) ? WIN_CYCLES : SETTLE;
    localparam int TMR_W   = clog2(TMR_MAX);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NBITS - 1);
    localparam logic [TMR_W-1:0] WIN_LOAD    = TMR_W'(WIN_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE - 1);

    state_t            state;
    logic [IDX_W-1:0]  bit_idx;
    logic              timer_load;
    logic [TMR_W-1:0]  timer_value;
    logic              timer_expire;

    // The timer is loaded in the cycle before the state it times: during
    // CLEAR for the RUN window, and in the last RUN cycle for SETTLE.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = WIN_LOAD;
        case (state)
            ST_CLEAR: timer_load = 1'b1;
            ST_RUN: begin
                if (timer_expire) begin
                    timer_load  = 1'b1;
                    timer_value = SETTLE_LOAD;
                end
            end
            default: ;
        endcase
    end

    puf_window_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .expire     (timer_expire)
    );

    // Outputs are set on the transition into the state that needs them, so
    // cnt_clr and osc_en are plain registers and never overlap.
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= ST_IDLE;
            bit_idx    <= '0;
            osc_sel    <= '0;
            osc_en     <= 1'b0;
            cnt_clr    <= 1'b0;
            busy       <= 1'b0;
            resp_data  <= '0;
            resp_ties  <= '0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        osc_sel   <= sel_start;
                        bit_idx   <= '0;
                        resp_data <= '0;
                        resp_ties <= '0;
                        busy      <= 1'b1;
                        cnt_clr   <= 1'b1;
                        state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    cnt_clr <= 1'b0;
                    osc_en  <= 1'b1;
                    state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (timer_expire) begin
                        osc_en <= 1'b0;
                        state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (timer_expire) state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    // A tie records 0 and is counted separately.
                    resp_data[bit_idx] <= (count_a > count_b);
                    if (count_a == count_b) resp_ties <= resp_ties + TIE_W'(1);
                    if (bit_idx == LAST_IDX) begin
                        resp_valid <= 1'b1;
                        state      <= ST_OUTPUT;
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                        osc_sel <= osc_sel + SEL_W'(1);
                        cnt_clr <= 1'b1;
                        state   <= ST_CLEAR;
                    end
                end
                ST_OUTPUT: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
